// File: rtl/fg_waveform_gen_if.sv
// Bundle of the waveform generator's streaming and configuration signals.
//   master : drives enable/phase/config, receives sample/valid/clip
//   slave  : the waveform generator itself
interface fg_waveform_gen_if #(
  parameter int PHASE_BW = 10,
  parameter int OUT_BW   = 8,
  parameter int AMP_BW   = 8
);
  logic                enable_i;
  logic                phase_valid_i;
  logic [PHASE_BW-1:0] phase_i;
  logic [1:0]          waveSel_i;
  logic [PHASE_BW-1:0] duty_i;
  logic [AMP_BW-1:0]   amplitude_i;
  logic [OUT_BW-1:0]   offset_i;
  logic [OUT_BW-1:0]   sample_o;
  logic                valid_o;
  logic                clip_o;

  modport master (
    output enable_i, phase_valid_i, phase_i, waveSel_i, duty_i, amplitude_i, offset_i,
    input  sample_o, valid_o, clip_o
  );

  modport slave (
    input  enable_i, phase_valid_i, phase_i, waveSel_i, duty_i, amplitude_i, offset_i,
    output sample_o, valid_o, clip_o
  );
endinterface

// File: rtl/fg_waveform_gen.sv
// Phase-to-sample stage fed by the FG timer. Every strobed phase value becomes one
// output sample (saw / triangle / square / parabolic sine), scaled by amplitude and
// offset with saturation. Three register stages, one sample per cycle, no stall.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset, clears every register
//   bus     : slave side of fg_waveform_gen_if
//             enable_i, phase_valid_i, phase_i, waveSel_i, duty_i, amplitude_i,
//             offset_i in; sample_o, valid_o, clip_o out
module fg_waveform_gen #(
  parameter int PHASE_BW = 10,
  parameter int OUT_BW   = 8,
  parameter int AMP_BW   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fg_waveform_gen_if.slave  bus
);

  localparam int N  = PHASE_BW;
  localparam int W  = OUT_BW;
  localparam int A  = AMP_BW;
  localparam int PW = W + A + 1;

  function automatic logic [W-1:0] shape(input logic [1:0]   sel,
                                         input logic [N-1:0] ph,
                                         input logic [N-1:0] duty);
    logic         m;
    logic [W-1:0] q;
    logic [2*W-1:0] prod;
    logic [W-1:0] h;
    m = ph[N-1];
    q = ph[N-2 -: W];
    // 2^W-1-q is simply the bitwise complement of q
    prod = {{W{1'b0}}, q} * {{W{1'b0}}, ~q};
    h    = W'(prod >> (W-1));
    case (sel)
      2'd0:    shape = ph[N-1 -: W];
      2'd1:    shape = m ? ~q : q;
      2'd2:    shape = (ph < duty) ? {W{1'b1}} : '0;
      default: shape = m ? ({1'b0, {(W-1){1'b1}}} - h) : ({1'b1, {(W-1){1'b0}}} + h);
    endcase
  endfunction

  // (amplitude+1)/2^A gain; the +1 makes all-ones amplitude an exact unity gain
  function automatic logic [W-1:0] scale(input logic [W-1:0] u, input logic [A-1:0] amp);
    logic [PW-1:0] p;
    p = PW'(u) * (PW'(amp) + PW'(1));
    scale = W'(p >> A);
  endfunction

  // Returns {clip, sample}
  function automatic logic [W:0] sat_add(input logic [W-1:0] s, input logic [W-1:0] off);
    logic [W:0] t;
    t = {1'b0, s} + {1'b0, off};
    sat_add = t[W] ? {1'b1, {W{1'b1}}} : {1'b0, t[W-1:0]};
  endfunction

  logic         vld_p0, vld_p1, vld_p2;
  logic [W-1:0] u_p0;
  logic [A-1:0] amp_p0;
  logic [W-1:0] off_p0, off_p1;
  logic [W-1:0] s_p1;
  logic [W-1:0] sample_p2;
  logic         clip_p2;
  logic [W:0]   sat_p1;

  assign sat_p1 = sat_add(s_p1, off_p1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0    <= 1'b0;
      u_p0      <= '0;
      amp_p0    <= '0;
      off_p0    <= '0;
      vld_p1    <= 1'b0;
      s_p1      <= '0;
      off_p1    <= '0;
      vld_p2    <= 1'b0;
      sample_p2 <= '0;
      clip_p2   <= 1'b0;
    end else begin
      // Stage 1: shape selection, all config captured together with the phase
      vld_p0 <= bus.enable_i & bus.phase_valid_i;
      u_p0   <= shape(bus.waveSel_i, bus.phase_i, bus.duty_i);
      amp_p0 <= bus.amplitude_i;
      off_p0 <= bus.offset_i;
      // Stage 2: amplitude scaling
      vld_p1 <= bus.enable_i & vld_p0;
      s_p1   <= scale(u_p0, amp_p0);
      off_p1 <= off_p0;
      // Stage 3: offset and saturation; idle level is the live offset when disabled
      if (!bus.enable_i) begin
        vld_p2    <= 1'b0;
        sample_p2 <= bus.offset_i;
        clip_p2   <= 1'b0;
      end else begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          clip_p2   <= sat_p1[W];
          sample_p2 <= sat_p1[W-1:0];
        end
      end
    end
  end

  assign bus.sample_o = sample_p2;
  assign bus.valid_o  = vld_p2;
  assign bus.clip_o   = clip_p2;

endmodule

// File: tb/tb_fg_waveform_gen.sv
// Directed bench for fg_waveform_gen: stimulus pushes hand-computed expectations
// (sample, clip, output cycle) into a scoreboard; a negedge monitor pops and compares.
module tb_fg_waveform_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fg_waveform_gen_if #(.PHASE_BW(10), .OUT_BW(8), .AMP_BW(8)) bus ();

  fg_waveform_gen #(.PHASE_BW(10), .OUT_BW(8), .AMP_BW(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] s;
    logic       c;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   compares = 0;
  int   fails = 0;

  always @(posedge clk) cyc++;

  // Monitor: every valid_o pulse must match the oldest expectation, on its cycle
  always @(negedge clk) begin
    if (!rst && bus.valid_o === 1'b1) begin
      compares++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got sample=%0d clip=%0d at cycle %0d, required no output",
                 bus.sample_o, bus.clip_o, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (bus.sample_o !== e.s || bus.clip_o !== e.c || cyc != e.cyc) begin
          fails++;
          $display("FAIL sample: got sample=%0d clip=%0d cycle=%0d, required sample=%0d clip=%0d cycle=%0d",
                   bus.sample_o, bus.clip_o, cyc, e.s, e.c, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    compares++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Drive one strobed phase; optionally register its expected result
  task automatic strobe(input logic [1:0] sel, input logic [9:0] ph, input logic [9:0] duty,
                        input logic [7:0] amp, input logic [7:0] off,
                        input bit push, input logic [7:0] es, input logic ec);
    exp_t e;
    bus.waveSel_i     = sel;
    bus.phase_i       = ph;
    bus.duty_i        = duty;
    bus.amplitude_i   = amp;
    bus.offset_i      = off;
    bus.phase_valid_i = 1'b1;
    if (push) begin
      e.s = es; e.c = ec; e.cyc = cyc + 3;
      sbq.push_back(e);
    end
    step();
  endtask

  task automatic idle(input int n);
    bus.phase_valid_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.enable_i      = 1'b0;
    bus.phase_valid_i = 1'b0;
    bus.phase_i       = '0;
    bus.waveSel_i     = 2'd0;
    bus.duty_i        = '0;
    bus.amplitude_i   = 8'd255;
    bus.offset_i      = '0;

    // Reset state
    #2;
    chk("reset_sample", int'(bus.sample_o), 0);
    chk("reset_valid",  int'(bus.valid_o), 0);
    chk("reset_clip",   int'(bus.clip_o), 0);
    step(); step();
    rst = 1'b0;
    bus.enable_i = 1'b1;
    step();

    // 1: saw 0x200 -> 0x80, then hold through bubbles
    strobe(2'd0, 10'h200, 10'h000, 8'd255, 8'd0, 1, 8'h80, 1'b0);
    idle(5);
    chk("hold_sample", int'(bus.sample_o), 8'h80);
    chk("hold_valid",  int'(bus.valid_o), 0);

    // 2: sine back-to-back
    strobe(2'd3, 10'h000, 10'h000, 8'd255, 8'd0, 1, 8'd128, 1'b0);
    strobe(2'd3, 10'h100, 10'h000, 8'd255, 8'd0, 1, 8'd255, 1'b0);
    strobe(2'd3, 10'h300, 10'h000, 8'd255, 8'd0, 1, 8'd0,   1'b0);
    // 3: triangle and square edges, duty 0 and zero amplitude
    strobe(2'd1, 10'h1FE, 10'h000, 8'd255, 8'd0, 1, 8'd255, 1'b0);
    strobe(2'd1, 10'h3FE, 10'h000, 8'd255, 8'd0, 1, 8'd0,   1'b0);
    strobe(2'd2, 10'h0FF, 10'h100, 8'd255, 8'd0, 1, 8'd255, 1'b0);
    strobe(2'd2, 10'h100, 10'h100, 8'd255, 8'd0, 1, 8'd0,   1'b0);
    strobe(2'd2, 10'h000, 10'h000, 8'd255, 8'd0, 1, 8'd0,   1'b0);
    strobe(2'd0, 10'h3FF, 10'h000, 8'd0,   8'd0, 1, 8'd0,   1'b0);
    // 4: saturation and its near miss
    strobe(2'd0, 10'h3FF, 10'h000, 8'd127, 8'd200, 1, 8'd255, 1'b1);
    strobe(2'd0, 10'h3FF, 10'h000, 8'd127, 8'd100, 1, 8'd227, 1'b0);
    idle(4);

    // 5: config changes right after a strobe must not affect it
    strobe(2'd0, 10'h200, 10'h100, 8'd255, 8'd0, 1, 8'h80, 1'b0);
    bus.waveSel_i   = 2'd2;
    bus.amplitude_i = 8'd0;
    bus.offset_i    = 8'hFF;
    idle(1);
    strobe(2'd2, 10'h080, 10'h100, 8'd255, 8'd10, 1, 8'd255, 1'b1);
    idle(4);

    // 6a: disable with two samples in flight
    strobe(2'd0, 10'h200, 10'h000, 8'd255, 8'd0, 0, 8'd0, 1'b0);
    strobe(2'd0, 10'h300, 10'h000, 8'd255, 8'd0, 0, 8'd0, 1'b0);
    bus.enable_i      = 1'b0;
    bus.offset_i      = 8'h55;
    bus.phase_valid_i = 1'b1;
    step(); step(); step();
    chk("idle_sample", int'(bus.sample_o), 8'h55);
    chk("idle_clip",   int'(bus.clip_o), 0);
    chk("idle_valid",  int'(bus.valid_o), 0);
    bus.phase_valid_i = 1'b0;
    bus.enable_i      = 1'b1;
    strobe(2'd0, 10'h200, 10'h000, 8'd255, 8'd0, 1, 8'h80, 1'b0);
    idle(4);

    // 6b: asynchronous reset mid-stream
    strobe(2'd0, 10'h3FF, 10'h000, 8'd127, 8'd200, 1, 8'd255, 1'b1);
    idle(3);
    chk("pre_rst_clip", int'(bus.clip_o), 1);
    strobe(2'd0, 10'h200, 10'h000, 8'd255, 8'd0, 0, 8'd0, 1'b0);
    bus.phase_valid_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_sample", int'(bus.sample_o), 0);
    chk("async_rst_clip",   int'(bus.clip_o), 0);
    chk("async_rst_valid",  int'(bus.valid_o), 0);
    rst = 1'b0;
    idle(6);

    // Everything expected must have been delivered
    chk("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
